// File: rtl/buffer_read_ctrl.sv
// buffer_read_ctrl
//   Read-side controller for the raw-hits FIFO RAM. A start pulse latches the
//   fence address, CFEB enables and tbin count. The controller then walks every
//   enabled CFEB, reading tbins words starting at (fence - pretrig). It waits
//   for the RAM pipeline to drain and finally releases the fence with buf_pop.
//   Optional feature macro: BUF_READ_WORDCNT_EN (rd_word_cnt counts fifo_ren clocks).
//
//   Start handshake: rd_start is a single-clock request with no ready signal.
//   It is accepted only when rd_busy is low. The clock after acceptance is
//   already counted as busy. A request that arrives while busy is dropped and
//   sets the sticky rd_start_err flag.
module buffer_read_ctrl #(
   parameter int MXTBIN   = 5,
   parameter int RAM_ADRB = 11,
   parameter int MXCFEB   = 5,
   parameter int MXCFEBB  = 3,
   parameter int RAM_LAT  = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rd_start,
   input  logic [RAM_ADRB-1:0] rd_adr,
   input  logic [MXCFEB-1:0]   rd_cfeb_en,
   input  logic [MXTBIN-1:0]   fifo_tbins,
   input  logic [MXTBIN-1:0]   fifo_pretrig,
   output logic                fifo_ren,
   output logic [RAM_ADRB-1:0] fifo_radr,
   output logic [MXCFEBB-1:0]  fifo_sel,
   output logic                rd_dvalid,
   output logic [MXCFEBB-1:0]  rd_dcfeb,
   output logic [MXTBIN-1:0]   rd_dtbin,
   output logic                rd_busy,
   output logic                rd_done,
   output logic                buf_pop,
   output logic [RAM_ADRB-1:0] buf_pop_adr,
   output logic                rd_start_err,
   output logic [15:0]         rd_word_cnt,
   output logic [1:0]          rd_state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_POP   = 2'd3
   } state_t;

   localparam int FLW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   state_t              state_q, state_d;
   logic                busy;
   logic                accept;
   logic                start_q;
   logic [RAM_ADRB-1:0] adr_q;
   logic [RAM_ADRB-1:0] sa_q;
   logic [MXCFEB-1:0]   en_q;
   logic [MXTBIN-1:0]   tbins_q;
   logic [MXTBIN-1:0]   tbin_q, tbin_d;
   logic [MXCFEBB-1:0]  cur_q, cur_d;
   logic [FLW-1:0]      fl_q, fl_d;
   logic                err_q;
   logic [MXCFEB-1:0]   above_mask;
   logic [MXCFEB-1:0]   rem_en;
   logic                last_tbin;

   logic                vpipe_q [RAM_LAT];
   logic [MXCFEBB-1:0]  spipe_q [RAM_LAT];
   logic [MXTBIN-1:0]   tpipe_q [RAM_LAT];

   // Index of the lowest set bit of an enable mask (0 when the mask is empty)
   function automatic logic [MXCFEBB-1:0] lowest_en(input logic [MXCFEB-1:0] m);
      logic [MXCFEBB-1:0] r;
      r = '0;
      for (int i = MXCFEB - 1; i >= 0; i--) begin
         if (m[i]) r = MXCFEBB'(i);
      end
      return r;
   endfunction

   // The accept clock (start_q) counts as busy, so the controller never takes two starts
   assign busy         = (state_q != ST_IDLE) || start_q;
   assign accept       = rd_start && !busy;
   assign rd_busy      = busy;
   assign rd_start_err = err_q;
   assign rd_state_dbg = state_q;

   // Accept a start request: latch the event description and flag starts that arrive while busy
   always_ff @(posedge clock) begin
      if (reset) begin
         start_q <= 1'b0;
         adr_q   <= '0;
         sa_q    <= '0;
         en_q    <= '0;
         tbins_q <= '0;
         err_q   <= 1'b0;
      end else begin
         start_q <= accept;
         if (accept) begin
            adr_q   <= rd_adr;
            sa_q    <= rd_adr - RAM_ADRB'(fifo_pretrig);
            en_q    <= rd_cfeb_en;
            tbins_q <= fifo_tbins;
         end
         if (rd_start && busy) err_q <= 1'b1;
      end
   end

   // FSM state and scan counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         tbin_q  <= '0;
         fl_q    <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tbin_q  <= tbin_d;
         fl_q    <= fl_d;
      end
   end

   // Next state, scan position and RAM/fence outputs
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      tbin_d      = tbin_q;
      fl_d        = fl_q;
      fifo_ren    = 1'b0;
      fifo_radr   = '0;
      fifo_sel    = '0;
      buf_pop     = 1'b0;
      rd_done     = 1'b0;
      buf_pop_adr = '0;
      // CFEBs strictly above the current one that still need reading
      above_mask  = ~((MXCFEB'(2) << cur_q) - MXCFEB'(1));
      rem_en      = en_q & above_mask;
      last_tbin   = (MXTBIN'(tbin_q + 1'b1) == tbins_q);
      case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               if (tbins_q == '0 || en_q == '0) begin
                  state_d = ST_POP;
               end else begin
                  state_d = ST_READ;
                  cur_d   = lowest_en(en_q);
                  tbin_d  = '0;
               end
            end
         end
         ST_READ: begin
            fifo_ren  = 1'b1;
            fifo_sel  = cur_q;
            fifo_radr = sa_q + RAM_ADRB'(tbin_q);
            if (last_tbin) begin
               tbin_d = '0;
               if (rem_en == '0) begin
                  state_d = ST_FLUSH;
                  fl_d    = '0;
               end else begin
                  cur_d = lowest_en(rem_en);
               end
            end else begin
               tbin_d = tbin_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            // Wait for the final read to come out of the RAM pipeline
            if (fl_q == FLW'(RAM_LAT - 1)) state_d = ST_POP;
            else fl_d = fl_q + 1'b1;
         end
         ST_POP: begin
            buf_pop     = 1'b1;
            rd_done     = 1'b1;
            buf_pop_adr = adr_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data-valid tag pipeline that tracks the RAM read latency
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            vpipe_q[i] <= 1'b0;
            spipe_q[i] <= '0;
            tpipe_q[i] <= '0;
         end
      end else begin
         vpipe_q[0] <= fifo_ren;
         spipe_q[0] <= fifo_sel;
         tpipe_q[0] <= fifo_ren ? tbin_q : '0;
         for (int i = 1; i < RAM_LAT; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
            spipe_q[i] <= spipe_q[i-1];
            tpipe_q[i] <= tpipe_q[i-1];
         end
      end
   end

   assign rd_dvalid = vpipe_q[RAM_LAT-1];
   assign rd_dcfeb  = spipe_q[RAM_LAT-1];
   assign rd_dtbin  = tpipe_q[RAM_LAT-1];

`ifdef BUF_READ_WORDCNT_EN
   logic [15:0] wc_q;

   // Saturating count of RAM read clocks, cleared only by reset
   always_ff @(posedge clock) begin
      if (reset) wc_q <= '0;
      else if (fifo_ren && wc_q != 16'hFFFF) wc_q <= wc_q + 16'd1;
   end

   assign rd_word_cnt = wc_q;
`else
   assign rd_word_cnt = '0;
`endif

endmodule
